// File: rtl/ctrl_pipe_regs.sv
// ID/EX, EX/MEM and MEM/WB control pipeline registers for the MIPS32 core.
// Sanitizes the decoded control bundle, detects load-use hazards and counts inserted bubbles.
module ctrl_pipe_regs #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [9:0]       id_ctrl,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             flush,
  input  logic             hold,
  output logic             stall,
  output logic             ex_valid,
  output logic [9:0]       ex_ctrl,
  output logic [RA_W-1:0]  ex_rs,
  output logic [RA_W-1:0]  ex_rt,
  output logic [RA_W-1:0]  ex_rd,
  output logic             mem_valid,
  output logic [4:0]       mem_ctrl,
  output logic [RA_W-1:0]  mem_wreg,
  output logic             wb_valid,
  output logic [1:0]       wb_ctrl,
  output logic [RA_W-1:0]  wb_wreg,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int unsigned REGDST = 9, JUMP = 8, BRANCH = 7, MEMREAD = 6, MEMTOREG = 5;
  localparam int unsigned MEMWRITE = 2, ALUSRC = 1, REGWRITE = 0;

  logic             ex_valid_q,  ex_valid_d;
  logic [9:0]       ex_ctrl_q,   ex_ctrl_d;
  logic [RA_W-1:0]  ex_rs_q,     ex_rs_d;
  logic [RA_W-1:0]  ex_rt_q,     ex_rt_d;
  logic [RA_W-1:0]  ex_rd_q,     ex_rd_d;
  logic             mem_valid_q, mem_valid_d;
  logic [4:0]       mem_ctrl_q,  mem_ctrl_d;
  logic [RA_W-1:0]  mem_wreg_q,  mem_wreg_d;
  logic             wb_valid_q,  wb_valid_d;
  logic [1:0]       wb_ctrl_q,   wb_ctrl_d;
  logic [RA_W-1:0]  wb_wreg_q,   wb_wreg_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  logic [9:0]      id_san;
  logic            use_rs, use_rt, stall_c;
  logic [RA_W-1:0] ex_wreg;
  logic [4:0]      ex_mctrl;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    id_san           = id_ctrl;
    id_san[REGDST]   = id_ctrl[REGDST] & id_ctrl[REGWRITE];
    id_san[MEMTOREG] = id_ctrl[MEMTOREG] & id_ctrl[REGWRITE];
    id_san[ALUSRC]   = id_ctrl[ALUSRC] & ~id_ctrl[JUMP];
    id_san[4:3]      = id_ctrl[4:3] & {2{~id_ctrl[JUMP]}};

    use_rs = id_ctrl[REGWRITE] | id_ctrl[MEMWRITE] | id_ctrl[BRANCH];
    use_rt = id_ctrl[MEMWRITE] | id_ctrl[BRANCH] |
             (id_ctrl[REGWRITE] & id_ctrl[REGDST] & ~id_ctrl[MEMREAD]);
    stall_c = id_valid & ex_valid_q & ex_ctrl_q[MEMREAD] & (ex_rt_q != '0) &
              ((use_rs & (id_rs == ex_rt_q)) | (use_rt & (id_rt == ex_rt_q)));

    ex_wreg  = ~ex_ctrl_q[REGWRITE] ? '0 : (ex_ctrl_q[REGDST] ? ex_rd_q : ex_rt_q);
    ex_mctrl = {ex_ctrl_q[BRANCH], ex_ctrl_q[MEMREAD], ex_ctrl_q[MEMWRITE],
                ex_ctrl_q[MEMTOREG], ex_ctrl_q[REGWRITE]};
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Bubbles carry all-zero control, so later stages never need to gate on valid.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_ctrl_d   = ex_ctrl_q;
    ex_rs_d     = ex_rs_q;
    ex_rt_d     = ex_rt_q;
    ex_rd_d     = ex_rd_q;
    mem_valid_d = mem_valid_q;
    mem_ctrl_d  = mem_ctrl_q;
    mem_wreg_d  = mem_wreg_q;
    wb_valid_d  = wb_valid_q;
    wb_ctrl_d   = wb_ctrl_q;
    wb_wreg_d   = wb_wreg_q;
    cnt_d       = cnt_q;
    if (!hold) begin
      wb_valid_d = mem_valid_q;
      wb_ctrl_d  = mem_ctrl_q[1:0];
      wb_wreg_d  = mem_wreg_q;
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      ex_rs_d    = '0;
      ex_rt_d    = '0;
      ex_rd_d    = '0;
      if (flush) begin
        mem_valid_d = 1'b0;
        mem_ctrl_d  = '0;
        mem_wreg_d  = '0;
        cnt_d       = cnt_inc;
      end else begin
        mem_valid_d = ex_valid_q;
        mem_ctrl_d  = ex_mctrl;
        mem_wreg_d  = ex_wreg;
        if (stall_c) begin
          cnt_d = cnt_inc;
        end else if (id_valid) begin
          ex_valid_d = 1'b1;
          ex_ctrl_d  = id_san;
          ex_rs_d    = id_rs;
          ex_rt_d    = id_rt;
          ex_rd_d    = id_rd;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_rd_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_wreg_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= '0;
      wb_wreg_q   <= '0;
      cnt_q       <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_rd_q     <= ex_rd_d;
      mem_valid_q <= mem_valid_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_wreg_q  <= mem_wreg_d;
      wb_valid_q  <= wb_valid_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_wreg_q   <= wb_wreg_d;
      cnt_q       <= cnt_d;
    end
  end

  assign stall      = stall_c;
  assign ex_valid   = ex_valid_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_rd      = ex_rd_q;
  assign mem_valid  = mem_valid_q;
  assign mem_ctrl   = mem_ctrl_q;
  assign mem_wreg   = mem_wreg_q;
  assign wb_valid   = wb_valid_q;
  assign wb_ctrl    = wb_ctrl_q;
  assign wb_wreg    = wb_wreg_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Directed bench for ctrl_pipe_regs; a 4-bit bubble counter keeps saturation reachable.
module tb_ctrl_pipe_regs;

  localparam int unsigned RA_W  = 5;
  localparam int unsigned CNT_W = 4;

  localparam logic [9:0] C_ADD    = 10'b1000010001;
  localparam logic [9:0] C_LW     = 10'b0001100011;
  localparam logic [9:0] C_SW_DC  = 10'b1000100110;  // RegDst/MemToReg don't-cares driven high
  localparam logic [9:0] C_SW     = 10'b0000000110;
  localparam logic [9:0] C_J_DC   = 10'b0100011010;  // ALUOp/ALUSrc don't-cares driven high
  localparam logic [9:0] C_J      = 10'b0100000000;

  logic clk = 1'b0;
  logic rst, id_valid, flush, hold;
  logic [9:0] id_ctrl;
  logic [RA_W-1:0] id_rs, id_rt, id_rd;
  logic stall, ex_valid, mem_valid, wb_valid;
  logic [9:0] ex_ctrl;
  logic [RA_W-1:0] ex_rs, ex_rt, ex_rd, mem_wreg, wb_wreg;
  logic [4:0] mem_ctrl;
  logic [1:0] wb_ctrl;
  logic [CNT_W-1:0] bubble_cnt;

  int errors = 0;
  int checks = 0;

  ctrl_pipe_regs #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .hold(hold),
    .stall(stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_ctrl(mem_ctrl),
    .mem_wreg(mem_wreg), .wb_valid(wb_valid), .wb_ctrl(wb_ctrl),
    .wb_wreg(wb_wreg), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [9:0] c, input int unsigned rs,
                       input int unsigned rt, input int unsigned rd);
    id_valid = v;
    id_ctrl  = c;
    id_rs    = RA_W'(rs);
    id_rt    = RA_W'(rt);
    id_rd    = RA_W'(rd);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    drive(1'b0, '0, 0, 0, 0);
    tick(); tick();
    checks++;
    if ({ex_valid, mem_valid, wb_valid, stall} !== 4'b0000) begin
      errors++; $display("FAIL reset_valids got=%b exp=0000", {ex_valid, mem_valid, wb_valid, stall});
    end
    checks++;
    if ({ex_ctrl, mem_ctrl, wb_ctrl, mem_wreg, wb_wreg, bubble_cnt} !== '0) begin
      errors++; $display("FAIL reset_fields ex_ctrl=%b mem_ctrl=%b wb_ctrl=%b cnt=%0d exp all 0",
                         ex_ctrl, mem_ctrl, wb_ctrl, bubble_cnt);
    end
    rst = 1'b0;
    drive(1'b1, C_ADD, 1, 2, 3);
    tick();
    drive(1'b0, '0, 0, 0, 0);
    checks++;
    if (ex_valid !== 1'b1 || ex_ctrl !== C_ADD || ex_rd !== 5'd3) begin
      errors++; $display("FAIL add_ex got v=%b ctrl=%b rd=%0d exp v=1 ctrl=%b rd=3", ex_valid, ex_ctrl, ex_rd, C_ADD);
    end
    tick();
    checks++;
    if (mem_valid !== 1'b1 || mem_ctrl !== 5'b00001 || mem_wreg !== 5'd3) begin
      errors++; $display("FAIL add_mem got v=%b ctrl=%b wreg=%0d exp v=1 ctrl=00001 wreg=3", mem_valid, mem_ctrl, mem_wreg);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_ctrl !== 2'b01 || wb_wreg !== 5'd3 || bubble_cnt !== 4'd0) begin
      errors++; $display("FAIL add_wb got v=%b ctrl=%b wreg=%0d cnt=%0d exp v=1 ctrl=01 wreg=3 cnt=0",
                         wb_valid, wb_ctrl, wb_wreg, bubble_cnt);
    end
  endtask

  task automatic test_load_use();
    drive(1'b1, C_LW, 1, 8, 0);
    tick();
    drive(1'b1, C_ADD, 8, 2, 9);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", stall); end
    tick();
    checks++;
    if (stall !== 1'b0 || ex_valid !== 1'b0 || ex_ctrl !== '0) begin
      errors++; $display("FAIL lu_bubble got stall=%b v=%b ctrl=%b exp 0 0 0", stall, ex_valid, ex_ctrl);
    end
    checks++;
    if (mem_valid !== 1'b1 || mem_ctrl !== 5'b01011 || mem_wreg !== 5'd8 || bubble_cnt !== 4'd1) begin
      errors++; $display("FAIL lu_mem got v=%b ctrl=%b wreg=%0d cnt=%0d exp 1 01011 8 1",
                         mem_valid, mem_ctrl, mem_wreg, bubble_cnt);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_ctrl !== C_ADD || ex_rs !== 5'd8) begin
      errors++; $display("FAIL lu_late got v=%b ctrl=%b rs=%0d exp 1 %b 8", ex_valid, ex_ctrl, ex_rs, C_ADD);
    end
    drive(1'b1, C_LW, 1, 0, 0);
    tick();
    drive(1'b1, C_ADD, 0, 0, 9);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_zero got=%b exp=0", stall); end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || bubble_cnt !== 4'd1) begin
      errors++; $display("FAIL lu_zero_adv got v=%b cnt=%0d exp 1 1", ex_valid, bubble_cnt);
    end
  endtask

  task automatic test_non_use();
    drive(1'b1, C_LW, 1, 8, 0);
    tick();
    drive(1'b1, C_J_DC, 8, 8, 8);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL nu_jump got=%b exp=0", stall); end
    tick();
    drive(1'b1, C_LW, 1, 8, 0);
    tick();
    drive(1'b1, C_SW_DC, 3, 8, 0);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL nu_store got=%b exp=1", stall); end
    tick();
    drive(1'b0, '0, 0, 0, 0);
    checks++;
    if (ex_valid !== 1'b0 || bubble_cnt !== 4'd2) begin
      errors++; $display("FAIL nu_store_bubble got v=%b cnt=%0d exp 0 2", ex_valid, bubble_cnt);
    end
  endtask

  task automatic test_sanitize();
    drive(1'b1, C_SW_DC, 3, 4, 7);
    tick();
    checks++;
    if ($isunknown(ex_ctrl) || ex_ctrl !== C_SW) begin
      errors++; $display("FAIL san_sw got=%b exp=%b", ex_ctrl, C_SW);
    end
    drive(1'b1, C_J_DC, 0, 0, 0);
    tick();
    checks++;
    if ($isunknown(ex_ctrl) || ex_ctrl !== C_J) begin
      errors++; $display("FAIL san_j got=%b exp=%b", ex_ctrl, C_J);
    end
    checks++;
    if (mem_ctrl !== 5'b00100 || mem_wreg !== 5'd0) begin
      errors++; $display("FAIL san_sw_mem got ctrl=%b wreg=%0d exp 00100 0", mem_ctrl, mem_wreg);
    end
    drive(1'b0, '0, 0, 0, 0);
  endtask

  task automatic test_flush();
    drive(1'b1, C_ADD, 1, 2, 5);
    tick();
    drive(1'b1, C_LW, 1, 8, 0);
    tick();
    drive(1'b1, C_ADD, 8, 2, 6);
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || mem_wreg !== 5'd5) begin
      errors++; $display("FAIL fl_setup got stall=%b mem_wreg=%0d exp 1 5", stall, mem_wreg);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || mem_valid !== 1'b0 || mem_ctrl !== '0) begin
      errors++; $display("FAIL fl_bubble got ex_v=%b mem_v=%b mem_ctrl=%b exp 0 0 0", ex_valid, mem_valid, mem_ctrl);
    end
    checks++;
    if (wb_valid !== 1'b1 || wb_ctrl !== 2'b01 || wb_wreg !== 5'd5 || bubble_cnt !== 4'd3) begin
      errors++; $display("FAIL fl_wb got v=%b ctrl=%b wreg=%0d cnt=%0d exp 1 01 5 3",
                         wb_valid, wb_ctrl, wb_wreg, bubble_cnt);
    end
    tick();
    hold = 1'b1;
    drive(1'b1, C_LW, 9, 9, 9);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_ctrl !== C_ADD || ex_rd !== 5'd6 || mem_valid !== 1'b0 ||
          wb_valid !== 1'b0 || wb_wreg !== 5'd0 || bubble_cnt !== 4'd3) begin
        errors++; $display("FAIL hold_%0d got ex=%b/%0d mem_v=%b wb_v=%b cnt=%0d exp %b/6 0 0 3",
                           i, ex_ctrl, ex_rd, mem_valid, wb_valid, bubble_cnt, C_ADD);
      end
    end
    hold = 1'b0;
    drive(1'b0, '0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    flush = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (bubble_cnt !== 4'hF) begin errors++; $display("FAIL sat_reach got=%0d exp=15", bubble_cnt); end
    tick(); tick();
    flush = 1'b0;
    checks++;
    if (bubble_cnt !== 4'hF) begin errors++; $display("FAIL sat_flush got=%0d exp=15", bubble_cnt); end
    drive(1'b1, C_LW, 1, 8, 0);
    tick();
    drive(1'b1, C_ADD, 8, 2, 9);
    tick();
    checks++;
    if (ex_valid !== 1'b0 || bubble_cnt !== 4'hF) begin
      errors++; $display("FAIL sat_stall got v=%b cnt=%0d exp 0 15", ex_valid, bubble_cnt);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, C_ADD, 1, 2, 3);
    tick(); tick(); tick();
    checks++;
    if ({ex_valid, mem_valid, wb_valid} !== 3'b111) begin
      errors++; $display("FAIL mid_full got=%b exp=111", {ex_valid, mem_valid, wb_valid});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ex_valid, mem_valid, wb_valid} !== 3'b000 || bubble_cnt !== '0) begin
      errors++; $display("FAIL mid_reset got=%b cnt=%0d exp 000 0", {ex_valid, mem_valid, wb_valid}, bubble_cnt);
    end
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_non_use();
    test_sanitize();
    test_flush();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
